bin2bcd_seq: RTL



---
 rtl/bin2bcd_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared definitions for the sequential binary-to-BCD converter.
//   - FSM state encodings (IDLE, SHIFT, DONE)
//   - min_digits(): decimal digits needed to hold any BIN_W-bit unsigned value
package bin2bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ceil(width * log10(2)) in fixed point; log10(2) ~= 0.301029996.
  // The rounding term is one unit below 1e9, so exact multiples are not bumped.
  function automatic int min_digits(input int width);
    longint unsigned num;
    longint unsigned quo;
    num = {32'd0, width} * 64'd301029996 + 64'd999999999;
    quo = num / 64'd1000000000;
    return int'(quo[31:0]);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction.
// Ports:
//   din  - 4-bit working BCD digit before the shift
//   dout - din + 3 when din >= 5, otherwise din unchanged
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: clocked shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   start, bin    - conversion request and operand (captured while ready=1)
//   ready         - idle, able to accept start
//   done          - one-cycle pulse; bcd/ovf/ndigits valid from this cycle on
//   bcd           - packed BCD result, digit 0 in [3:0]
//   ovf           - value did not fit in DIGITS digits (bcd holds value mod 10^DIGITS)
//   ndigits       - significant digit count, 1..DIGITS
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | ready, waiting for start
// ST_SHIFT | adjust + shift one bit per cycle, BIN_W cycles
// ST_DONE  | done pulse, results presented on outputs
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int NDIG_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [NDIG_W-1:0]     ndigits
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]  work_q, work_d;
  logic              flag_q, flag_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [NDIG_W-1:0] nd_q, nd_d;

  logic [BCD_W-1:0]  work_adj;
  logic [BCD_W-1:0]  work_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_q[4*g +: 4]),
      .dout (work_adj[4*g +: 4])
    );
  end

  // The MSB of work_adj is the bit lost off the top digit on this shift.
  assign work_shift = {work_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};

  function automatic logic [NDIG_W-1:0] count_digits(input logic [BCD_W-1:0] v);
    logic [NDIG_W-1:0] n;
    n = NDIG_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = NDIG_W'(i + 1);
    end
    return n;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_sr_d = bin_sr_q;
    work_d   = work_q;
    flag_d   = flag_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    nd_d     = nd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_sr_d = bin;
          work_d   = '0;
          flag_d   = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d   = work_shift;
        bin_sr_d = bin_sr_q << 1;
        flag_d   = flag_q | work_adj[BCD_W-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          // Results are loaded on the edge into DONE so they are already
          // valid while done is high.
          bcd_d   = work_shift;
          ovf_d   = flag_d;
          nd_d    = flag_d ? NDIG_W'(DIGITS) : count_digits(work_shift);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bin_sr_q <= '0;
      work_q   <= '0;
      flag_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      nd_q     <= NDIG_W'(1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_sr_q <= bin_sr_d;
      work_q   <= work_d;
      flag_q   <= flag_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      nd_q     <= nd_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign bcd     = bcd_q;
  assign ovf     = ovf_q;
  assign ndigits = nd_q;

endmodule
